// File: rtl/aes_inv_pkg.sv
// ---------------------------------------------------------------------------
// aes_inv_pkg
// Shared types and GF(2^8) helpers for the iterative AES-128 decryptor.
//   - aes_fsm_e       : controller states (IDLE / KEYEXP / ROUND)
//   - rcon()          : round constants for rounds 1..10
//   - xtime/gf_mul    : GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1
//   - sbox/inv_sbox   : computed S-box (field inverse plus affine map)
//   - sub_word/rot_word, fwd_key_step/inv_key_step : key schedule steps
// ---------------------------------------------------------------------------
package aes_inv_pkg;

  localparam int AES_DATA_W = 128;
  localparam int AES_NR     = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUND  = 2'd2
  } aes_fsm_e;

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    case (idx)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240;
    a2   = gf_mul(a, a);
    a3   = gf_mul(a2, a);
    a6   = gf_mul(a3, a3);
    a12  = gf_mul(a6, a6);
    a15  = gf_mul(a12, a3);
    a30  = gf_mul(a15, a15);
    a60  = gf_mul(a30, a30);
    a120 = gf_mul(a60, a60);
    a240 = gf_mul(a120, a120);
    return gf_mul(gf_mul(a240, a12), a2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x;
    x = gf_inv(a);
    return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
             ^ {x[3:0], x[7:4]} ^ 8'h63;
  endfunction

  // Undo the affine map first, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y;
    y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(y);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Walks the schedule one round backwards; w3 is recovered first because
  // the previous round's last word feeds the SubWord term of word 0.
  function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w3 = w3 ^ w2;
    w2 = w2 ^ w1;
    w1 = w1 ^ w0;
    w0 = w0 ^ sub_word(rot_word(w3)) ^ {rc, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// ---------------------------------------------------------------------------
// aes_inv_round
// Combinational AES inverse round:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
// InvMixColumns is bypassed when last_round_i is set.
// Ports:
//   state_i      [127:0] in   current state, byte 0 at [127:120], column-major
//   rk_i         [127:0] in   round key for this round
//   last_round_i         in   final round, skip InvMixColumns
//   state_o      [127:0] out  next state
// ---------------------------------------------------------------------------
module aes_inv_round
  import aes_inv_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_round_i,
  output logic [127:0] state_o
);

  logic [127:0] subbed;
  logic [127:0] added;
  logic [127:0] mixed;
  logic [7:0]   a0, a1, a2, a3;

  always_comb begin
    subbed = '0;
    mixed  = '0;
    a0     = '0;
    a1     = '0;
    a2     = '0;
    a3     = '0;
    // Row r of the output takes column (c - r) mod 4 of the input.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        subbed[127 - 8*(r + 4*c) -: 8] =
          inv_sbox(state_i[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8]);
      end
    end
    added = subbed ^ rk_i;
    for (int c = 0; c < 4; c++) begin
      a0 = added[127 - 32*c -: 8];
      a1 = added[119 - 32*c -: 8];
      a2 = added[111 - 32*c -: 8];
      a3 = added[103 - 32*c -: 8];
      mixed[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      mixed[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      mixed[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      mixed[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    state_o = last_round_i ? added : mixed;
  end

endmodule

// File: rtl/aes_inv_top.sv
// ---------------------------------------------------------------------------
// aes_inv_top
// Iterative AES-128 decryptor, one round per clock, no round-key storage.
// The cipher key is expanded forward to round-key 10 (10 clocks), then the
// block is decrypted while the key schedule is run backwards (10 clocks).
// Ports:
//   AES_clk                  in   clock, rising edge
//   AES_rst_n                in   synchronous active-low reset
//   AES_en                   in   start request, rising edge detected
//   AES_data_in        [127:0] in   ciphertext, captured at start
//   AES_key_in         [127:0] in   cipher key, captured at start
//   AES_data_out       [127:0] out  plaintext, holds last result
//   AES_data_out_valid       out  one-cycle pulse on each new result
// Build option:
//   AES_INV_KEY_CACHE_EN : remembers round-keys 0 and 10 of the last key so
//   a repeated key skips the forward expansion (10-cycle latency).
// ---------------------------------------------------------------------------
module aes_inv_top
  import aes_inv_pkg::*;
#(
  parameter int DATA_W = AES_DATA_W,
  parameter int NR     = AES_NR
) (
  input  logic              AES_clk,
  input  logic              AES_rst_n,
  input  logic              AES_en,
  input  logic [DATA_W-1:0] AES_data_in,
  input  logic [DATA_W-1:0] AES_key_in,
  output logic [DATA_W-1:0] AES_data_out,
  output logic              AES_data_out_valid
);

  aes_fsm_e          fsm_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] ct_q;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] state_q;
  logic [DATA_W-1:0] data_out_q;
  logic              valid_q;
  logic              en_q;

  logic              start_d;
  logic [DATA_W-1:0] key_fwd_d;
  logic [DATA_W-1:0] key_prev_d;
  logic [DATA_W-1:0] round_d;

`ifdef AES_INV_KEY_CACHE_EN
  logic [DATA_W-1:0] cache_k0_q;
  logic [DATA_W-1:0] cache_k10_q;
  logic              cache_vld_q;
  logic              cache_hit_d;

  assign cache_hit_d = cache_vld_q && (AES_key_in == cache_k0_q);
`endif

  assign start_d = AES_en & ~en_q;

  // In KEYEXP key_q holds round-key cnt-1; in ROUND it holds round-key cnt+1,
  // so the backward step always uses rcon of the round it is leaving.
  assign key_fwd_d  = fwd_key_step(key_q, rcon(cnt_q));
  assign key_prev_d = inv_key_step(key_q, rcon(cnt_q + 4'd1));

  aes_inv_round u_round (
    .state_i      (state_q),
    .rk_i         (key_prev_d),
    .last_round_i (cnt_q == 4'd0),
    .state_o      (round_d)
  );

  always_ff @(posedge AES_clk) begin
    if (!AES_rst_n) begin
      fsm_q      <= ST_IDLE;
      cnt_q      <= '0;
      ct_q       <= '0;
      key_q      <= '0;
      state_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      en_q       <= 1'b0;
`ifdef AES_INV_KEY_CACHE_EN
      cache_k0_q  <= '0;
      cache_k10_q <= '0;
      cache_vld_q <= 1'b0;
`endif
    end else begin
      en_q    <= AES_en;
      valid_q <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (start_d) begin
`ifdef AES_INV_KEY_CACHE_EN
            if (cache_hit_d) begin
              state_q <= AES_data_in ^ cache_k10_q;
              key_q   <= cache_k10_q;
              cnt_q   <= 4'(NR - 1);
              fsm_q   <= ST_ROUND;
            end else begin
              ct_q  <= AES_data_in;
              key_q <= AES_key_in;
              cnt_q <= 4'd1;
              fsm_q <= ST_KEYEXP;
            end
`else
            ct_q  <= AES_data_in;
            key_q <= AES_key_in;
            cnt_q <= 4'd1;
            fsm_q <= ST_KEYEXP;
`endif
          end
        end

        ST_KEYEXP: begin
          key_q <= key_fwd_d;
          if (cnt_q == 4'(NR)) begin
            // Round-key 10 is ready: fold in the initial AddRoundKey.
            state_q <= ct_q ^ key_fwd_d;
            cnt_q   <= 4'(NR - 1);
            fsm_q   <= ST_ROUND;
`ifdef AES_INV_KEY_CACHE_EN
            cache_k10_q <= key_fwd_d;
            cache_vld_q <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end

        ST_ROUND: begin
          key_q <= key_prev_d;
          if (cnt_q == 4'd0) begin
            data_out_q <= round_d;
            valid_q    <= 1'b1;
            fsm_q      <= ST_IDLE;
`ifdef AES_INV_KEY_CACHE_EN
            cache_k0_q  <= key_prev_d;
            cache_vld_q <= 1'b1;
`endif
          end else begin
            state_q <= round_d;
            cnt_q   <= cnt_q - 4'd1;
          end
        end

        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign AES_data_out       = data_out_q;
  assign AES_data_out_valid = valid_q;

endmodule
